// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch datapath (element aggregator and
// fetch_word_buffer): default element/word geometry, the lane-count type and
// the fetch width that the datapath comes out of reset with.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FETCH_WIDTH_DEF = 40;
    localparam int LANE_W_DEF      = $clog2(FETCH_WIDTH_DEF + 1);

    // Number of meaningful lanes in a word (0..FETCH_WIDTH inclusive).
    typedef logic [LANE_W_DEF-1:0] lane_cnt_t;

    // After reset every lane of a word is meaningful.
    localparam lane_cnt_t RESET_FETCH_WIDTH = lane_cnt_t'(FETCH_WIDTH_DEF);

    // The width request bus is narrower than a lane count; zero-extend it.
    function automatic lane_cnt_t widen_fetch_width(input logic [2:0] width_req);
        return lane_cnt_t'(width_req);
    endfunction

endpackage

// File: rtl/fetch_lane_mask.sv
// -----------------------------------------------------------------------------
// fetch_lane_mask
// Combinational lane mask: passes lanes with index < lanes_i and forces every
// higher lane to zero, so a consumer never sees stale aggregator data.
// Only compiled when FETCH_BUF_LANE_MASK_EN is defined.
//
// Ports:
//   lanes_i  number of meaningful lanes in word_i
//   word_i   packed word, lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   word_o   word_i with lanes >= lanes_i cleared
// -----------------------------------------------------------------------------
`ifdef FETCH_BUF_LANE_MASK_EN
module fetch_lane_mask #(
    parameter int DATA_WIDTH  = 16,
    parameter int FETCH_WIDTH = 40,
    parameter int LANE_W      = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [LANE_W-1:0]                 lanes_i,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] word_i,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] word_o
);

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
        assign word_o[g*DATA_WIDTH +: DATA_WIDTH] =
            (lanes_i > LANE_W'(g)) ? word_i[g*DATA_WIDTH +: DATA_WIDTH]
                                   : {DATA_WIDTH{1'b0}};
    end

endmodule
`endif

// File: rtl/fetch_word_buffer.sv
// -----------------------------------------------------------------------------
// fetch_word_buffer
// First-word-fall-through FIFO of wide fetch words. Each word is tagged with
// the fetch width (valid lane count) active when it was written; the head word
// and its tag are presented combinationally to the consumer.
//
// Configuration macro: FETCH_BUF_LANE_MASK_EN
//   defined     -> lanes >= deq_lanes of deq_data read as zero (all zero when
//                  empty_n = 0)
//   not defined -> deq_data is the raw stored word
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   enq_data, enq       word to write, write request
//   full_n              space available (low during rst)
//   change_fetch_width  load input_fetch_width as the active width
//   input_fetch_width   new active width in lanes (zero-extended)
//   deq_data, deq_lanes head word and its valid-lane count (0 when empty)
//   deq                 pop request
//   empty_n             head word valid
//   overflow            sticky: an enq arrived while full_n = 0
// -----------------------------------------------------------------------------
module fetch_word_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int DEPTH       = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]           enq_data,
    input  logic                                        enq,
    output logic                                        full_n,
    input  logic                                        change_fetch_width,
    input  logic [2:0]                                  input_fetch_width,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0]           deq_data,
    output logic [$clog2(FETCH_WIDTH+1)-1:0]            deq_lanes,
    input  logic                                        deq,
    output logic                                        empty_n,
    output logic                                        overflow
);

    localparam int LANE_W = $clog2(FETCH_WIDTH + 1);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WORD_W = FETCH_WIDTH * DATA_WIDTH;

    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_EMPTY   = CNT_W'(0);
    localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(DEPTH - 1);
    localparam logic [LANE_W-1:0] WIDTH_RESET = LANE_W'(FETCH_WIDTH);

    // Storage; deliberately not reset, the count alone says what is valid.
    logic [WORD_W-1:0] data_mem_q [DEPTH];
    logic [LANE_W-1:0] tag_mem_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [LANE_W-1:0] width_q,  width_d;
    logic              overflow_q, overflow_d;

    logic              push_s;
    logic              pop_s;
    logic [WORD_W-1:0] raw_word_s;

    // Flags come only from registered state (and rst); no path from enq/deq.
    assign full_n  = (count_q != CNT_FULL) & ~rst;
    assign empty_n = (count_q != CNT_EMPTY);

    // full_n already folds in rst and a full FIFO, so no bypass on full.
    assign push_s = enq & full_n;
    assign pop_s  = deq & empty_n;

    // Next-state logic for pointers, occupancy, active width and overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        width_d    = width_q;
        overflow_d = overflow_q;

        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The word written this cycle is tagged from width_q, so a width
        // change in the same cycle only affects later writes.
        if (change_fetch_width) begin
            width_d = LANE_W'(input_fetch_width);
        end else begin
            width_d = width_q;
        end

        if (enq && !full_n) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            width_q    <= WIDTH_RESET;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            width_q    <= width_d;
            overflow_q <= overflow_d;
        end
    end

    // Word and tag storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_q[wr_ptr_q] <= enq_data;
            tag_mem_q[wr_ptr_q]  <= width_q;
        end
    end

    assign raw_word_s = data_mem_q[rd_ptr_q];
    assign deq_lanes  = empty_n ? tag_mem_q[rd_ptr_q] : LANE_W'(0);
    assign overflow   = overflow_q;

`ifdef FETCH_BUF_LANE_MASK_EN
    // deq_lanes is 0 when empty, which clears every lane of the head word.
    fetch_lane_mask #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH),
        .LANE_W      (LANE_W)
    ) u_lane_mask (
        .lanes_i (deq_lanes),
        .word_i  (raw_word_s),
        .word_o  (deq_data)
    );
`else
    assign deq_data = raw_word_s;
`endif

endmodule

// File: tb/tb_fetch_word_buffer.sv
module tb_fetch_word_buffer;
    import fetch_pkg::*;

    localparam int DW    = 16;
    localparam int FW    = 40;
    localparam int DEPTH = 4;
    localparam int WW    = DW * FW;

    typedef logic [WW-1:0] word_t;
    typedef struct {
        word_t     data;
        lane_cnt_t lanes;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    word_t       enq_data;
    logic        enq;
    logic        full_n;
    logic        change_fetch_width;
    logic [2:0]  input_fetch_width;
    word_t       deq_data;
    lane_cnt_t   deq_lanes;
    logic        deq;
    logic        empty_n;
    logic        overflow;

    fetch_word_buffer #(
        .DATA_WIDTH  (DW),
        .FETCH_WIDTH (FW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enq_data           (enq_data),
        .enq                (enq),
        .full_n             (full_n),
        .change_fetch_width (change_fetch_width),
        .input_fetch_width  (input_fetch_width),
        .deq_data           (deq_data),
        .deq_lanes          (deq_lanes),
        .deq                (deq),
        .empty_n            (empty_n),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a queue of tagged words plus active width and
    // sticky overflow flag.
    ent_t      m_q[$];
    lane_cnt_t m_width;
    bit        m_ovf;

    task automatic chk(input string name, input word_t act, input word_t exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word whose lane 0 equals s and whose other lanes are nonzero.
    function automatic word_t mk(input int s);
        word_t w;
        for (int i = 0; i < FW; i++) begin
            w[i*DW +: DW] = (i == 0) ? DW'(s) : DW'(s * 64 + i);
        end
        return w;
    endfunction

    function automatic word_t lane0(input word_t w);
        return word_t'(w[DW-1:0]);
    endfunction

    // What the consumer should see for a given head entry.
    function automatic word_t exp_word(input ent_t e);
        word_t w;
        w = e.data;
`ifdef FETCH_BUF_LANE_MASK_EN
        for (int i = 0; i < FW; i++) begin
            if (i >= int'(e.lanes)) w[i*DW +: DW] = '0;
        end
`endif
        return w;
    endfunction

    // Per-cycle compare against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("empty_n", word_t'(empty_n), word_t'(m_q.size() != 0));
            chk("full_n", word_t'(full_n), word_t'(!rst && m_q.size() != DEPTH));
            chk("overflow", word_t'(overflow), word_t'(m_ovf));
            if (m_q.size() != 0) begin
                chk("deq_lanes", word_t'(deq_lanes), word_t'(m_q[0].lanes));
                chk("deq_data", deq_data, exp_word(m_q[0]));
            end else begin
                chk("deq_lanes_empty", word_t'(deq_lanes), '0);
`ifdef FETCH_BUF_LANE_MASK_EN
                chk("deq_data_empty", deq_data, '0);
`endif
            end
        end
    end

    // One clock cycle: drive inputs at the falling edge, update the model at
    // the rising edge, return at the next falling edge.
    task automatic step(input bit e, input word_t d, input bit p,
                        input bit c, input logic [2:0] w, input bit r);
        bit m_full, do_push, do_pop;
        enq = e; enq_data = d; deq = p;
        change_fetch_width = c; input_fetch_width = w; rst = r;
        m_full  = r || (m_q.size() == DEPTH);
        do_push = e && !m_full;
        do_pop  = p && (m_q.size() != 0);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_width = RESET_FETCH_WIDTH;
            m_ovf   = 1'b0;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back('{data: d, lanes: m_width});
            if (e && m_full) m_ovf = 1'b1;
            if (c) m_width = lane_cnt_t'(w);
        end
        @(negedge clk);
    endtask

    task automatic push(input int s);
        step(1'b1, mk(s), 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, '0, 1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b1);
    endtask

    initial begin
        word_t upper_exp;
        rst = 1'b1; enq = 1'b0; deq = 1'b0; enq_data = '0;
        change_fetch_width = 1'b0; input_fetch_width = 3'd0;
        m_width = RESET_FETCH_WIDTH; m_ovf = 1'b0;
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // Reset values while rst is still high, then full_n rises.
        chk("rst_full_n", word_t'(full_n), '0);
        chk("rst_empty_n", word_t'(empty_n), '0);
        chk("rst_overflow", word_t'(overflow), '0);
        chk("rst_deq_lanes", word_t'(deq_lanes), '0);
        idle();
        chk("post_rst_full_n", word_t'(full_n), word_t'(1));

        // Fill with lane0 = 1..4, then drain in order.
        for (int k = 1; k <= 4; k++) push(k);
        chk("fill_full_n", word_t'(full_n), '0);
        for (int k = 1; k <= 4; k++) begin
            chk("fill_lane0", lane0(deq_data), word_t'(k));
            chk("fill_lanes", word_t'(deq_lanes), word_t'(40));
            pop();
        end
        chk("drain_empty_n", word_t'(empty_n), '0);

        // Width change in the same cycle as push A: A keeps 40, B gets 5.
        step(1'b1, mk(10), 1'b0, 1'b1, 3'd5, 1'b0);
        push(11);
        chk("wchg_a_lanes", word_t'(deq_lanes), word_t'(40));
        pop();
        chk("wchg_b_lanes", word_t'(deq_lanes), word_t'(5));
        chk("wchg_b_lane0", lane0(deq_data), word_t'(11));
`ifdef FETCH_BUF_LANE_MASK_EN
        upper_exp = '0;
`else
        upper_exp = mk(11) >> (5 * DW);
`endif
        chk("wchg_b_upper", deq_data >> (5 * DW), upper_exp);
        pop();

        // Width 0 is legal and stored as-is.
        step(1'b0, '0, 1'b0, 1'b1, 3'd0, 1'b0);
        push(12);
        chk("w0_empty_n", word_t'(empty_n), word_t'(1));
        chk("w0_lanes", word_t'(deq_lanes), '0);
        pop();
        do_reset();
        idle();

        // Overflow: push into a full FIFO is dropped and sticky.
        for (int k = 20; k <= 23; k++) push(k);
        push(99);
        chk("ovf_set", word_t'(overflow), word_t'(1));
        for (int k = 20; k <= 23; k++) begin
            chk("ovf_lane0", lane0(deq_data), word_t'(k));
            pop();
        end
        chk("ovf_sticky", word_t'(overflow), word_t'(1));
        pop();  // deq while empty is ignored
        chk("deq_empty_ignored", word_t'(empty_n), '0);
        do_reset();
        chk("ovf_cleared", word_t'(overflow), '0);
        idle();

        // Steady state at count 2 with push+pop each cycle; pointers wrap.
        push(30);
        push(31);
        for (int i = 0; i < 10; i++) step(1'b1, mk(32 + i), 1'b1, 1'b0, 3'd0, 1'b0);
        chk("stream_lane0", lane0(deq_data), word_t'(40));
        chk("stream_full_n", word_t'(full_n), word_t'(1));
        pop();
        chk("stream_lane0_next", lane0(deq_data), word_t'(41));
        pop();
        chk("stream_empty", word_t'(empty_n), '0);

        // Push and pop on an empty FIFO: the push wins.
        step(1'b1, mk(50), 1'b1, 1'b0, 3'd0, 1'b0);
        chk("pp_empty_n", word_t'(empty_n), word_t'(1));
        chk("pp_lane0", lane0(deq_data), word_t'(50));
        pop();

        // Reset mid-stream discards words and restores width 40.
        step(1'b0, '0, 1'b0, 1'b1, 3'd3, 1'b0);
        push(60);
        push(61);
        push(62);
        do_reset();
        chk("mid_rst_empty_n", word_t'(empty_n), '0);
        chk("mid_rst_lanes", word_t'(deq_lanes), '0);
        idle();
        chk("mid_rst_full_n", word_t'(full_n), word_t'(1));
        push(63);
        chk("mid_rst_width", word_t'(deq_lanes), word_t'(40));
        chk("mid_rst_lane0", lane0(deq_data), word_t'(63));
        pop();
        idle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_word_buffer.md
# fetch_word_buffer

Wide-word FIFO directly downstream of the element aggregator: accepts one packed word of up to FETCH_WIDTH elements per enqueue, tags each word with the fetch width active at write time, and presents words first-word-fall-through to the consumer (query-patch / internal-node / leaf loaders). Decouples the aggregator's `receiver_enq`/`receiver_full_n` handshake from consumer stalls, and tells the consumer how many lanes of each word are meaningful.

## Interface
- `DATA_WIDTH`, 16, bits per element
- `FETCH_WIDTH`, 40, elements per word (max lanes)
- `DEPTH`, 4, word entries; power of two, ≥2
- `LANE_W`, `$clog2(FETCH_WIDTH+1)` (derived, localparam), lane-count width
- `clk` input 1: single clock, all state on rising edge
- `rst` input 1: reset, synchronous, active-high
- `enq_data` input FETCH_WIDTH*DATA_WIDTH: packed word, lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- `enq` input 1: write request
- `full_n` output 1: space available
- `change_fetch_width` input 1: load new active width
- `input_fetch_width` input 3: new active width (lanes), zero-extended
- `deq_data` output FETCH_WIDTH*DATA_WIDTH: head word
- `deq_lanes` output LANE_W: valid-lane count tagged on head word
- `deq` input 1: pop request
- `empty_n` output 1: head word valid
- `overflow` output 1: sticky, set on enq while `full_n`=0

## Operation
- Active width register: reset to FETCH_WIDTH; loads `input_fetch_width` on `change_fetch_width`; value 0 is legal and stored as-is.
- Write: `enq && full_n` stores `enq_data` and current active width into entry at write pointer; pointer wraps DEPTH-1 → 0.
- Write with `change_fetch_width` same cycle: word tagged with the OLD width; new width applies to subsequent writes.
- Read: `deq && empty_n` advances read pointer (wraps). `deq` while empty ignored, no state change.
- `enq` while full: word dropped, `overflow` set; cleared only by `rst`.
- Simultaneous push and pop, 0<count<DEPTH: both occur, count unchanged. At count=DEPTH: push refused (`full_n`=0, no bypass), pop occurs. At count=0: pop ignored, push occurs.
- Count register 0..DEPTH (width `$clog2(DEPTH+1)`); `full_n` = (count≠DEPTH) & !rst; `empty_n` = (count≠0).
- `deq_data`/`deq_lanes` driven combinationally from head entry; contents undefined when `empty_n`=0 (lane mask below still applies).
- Reset mid-operation: all stored words discarded, pointers/count to 0, active width to FETCH_WIDTH; storage array itself not cleared.

## Timing
- Reset values: `full_n`=0 during `rst`, 1 the cycle after; `empty_n`=0; `overflow`=0; `deq_lanes`=0 (count 0 forces tag output 0).
- Write latency: word pushed at edge N is visible with `empty_n`=1 from edge N (readable in cycle N+1).
- Pop at edge N exposes next entry in cycle N+1; throughput one push and one pop per cycle.
- `full_n` and `empty_n` depend only on registered state (no combinational path from `enq`/`deq`).

## Configuration
- `FETCH_BUF_LANE_MASK_EN` defined: `deq_data` lanes with index ≥ `deq_lanes` forced to zero; all lanes zero when `empty_n`=0.
- Not defined: `deq_data` is raw stored word; upper lanes carry whatever the aggregator left (stale data); no mask logic synthesized.

## Structure
- Shared package `fetch_pkg`: DATA_WIDTH/FETCH_WIDTH defaults, `lane_cnt_t` typedef (LANE_W bits), reset fetch-width constant; same package used by the aggregator.
- Sub-module `fetch_lane_mask` (combinational, lane count + word in, masked word out), instantiated only under `FETCH_BUF_LANE_MASK_EN`.
- Storage: array of DEPTH words plus parallel array of DEPTH lane tags, pointer/count logic in top.

## Test plan
- Reset then 4 pushes of words with lane0=1..4, no pops → `full_n`=0 after 4th; pops return lane0 1,2,3,4 in order, `deq_lanes`=40 each.
- `change_fetch_width`=1, `input_fetch_width`=5 same cycle as push A, then push B → A tagged 40, B tagged 5; with mask enabled B lanes 5..39 read 0.
- Fill to 4, assert `enq` with new word → word dropped, `overflow`=1 stays 1 until `rst`; FIFO contents unchanged.
- Count=2, push and pop every cycle for 10 cycles → count stays 2, output order matches input, pointers wrap without loss.
- Empty FIFO, `deq`=1 and `enq`=1 same cycle with word W → W retained, `empty_n`=1 next cycle, count=1.
- Push 3 words, assert `rst` 1 cycle mid-stream → `empty_n`=0, `full_n`=1 the cycle after, `deq_lanes`=0, active width back to 40.
